// File: rtl/trap_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl_if
//  Description : Commit-stage request bundle and CSR exception write port
//                shared between the pipeline (master) and the trap
//                controller (slave).
//                Inputs to the controller: valid_i, pc_i, instr_i, exc_i,
//                badaddr_i, mret_i, irq_i, mstatus_i, mie_i, mepc_i,
//                mcause_i, mtval_i.
//                Outputs from the controller: we_exc_o, mcause_o, mepc_o,
//                mtval_o, mstatus_o, aux_o, flush_o, busy_o.
//  Revision    : 1.0 - initial release
// ============================================================================
interface trap_ctrl_if #(
    parameter int XLEN = 32
);
    // Commit-stage request and current CSR state
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic [5:0]      exc_i;
    logic [XLEN-1:0] badaddr_i;
    logic            mret_i;
    logic [2:0]      irq_i;
    logic [XLEN-1:0] mstatus_i;
    logic [XLEN-1:0] mie_i;
    logic [XLEN-1:0] mepc_i;
    logic [XLEN-1:0] mcause_i;
    logic [XLEN-1:0] mtval_i;

    // CSR exception write port and pipeline control
    logic            we_exc_o;
    logic [XLEN-1:0] mcause_o;
    logic [XLEN-1:0] mepc_o;
    logic [XLEN-1:0] mtval_o;
    logic [XLEN-1:0] mstatus_o;
    logic            aux_o;
    logic            flush_o;
    logic            busy_o;

    modport master (
        output valid_i, pc_i, instr_i, exc_i, badaddr_i, mret_i, irq_i,
               mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
        input  we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o,
               aux_o, flush_o, busy_o
    );

    modport slave (
        input  valid_i, pc_i, instr_i, exc_i, badaddr_i, mret_i, irq_i,
               mstatus_i, mie_i, mepc_i, mcause_i, mtval_i,
        output we_exc_o, mcause_o, mepc_o, mtval_o, mstatus_o,
               aux_o, flush_o, busy_o
    );
endinterface
`default_nettype wire

// File: rtl/trap_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : trap_ctrl
//  Description : Trap/exception controller. Samples the committing
//                instruction, prioritises interrupts over synchronous
//                exceptions over MRET, and issues a one-cycle CSR exception
//                write followed by FLUSH_CYCLES drain cycles while the
//                pipeline is stalled.
//  Ports       : clk_i  - clock
//                rst_ni - asynchronous active-low reset
//                bus    - trap_ctrl_if.slave (commit request in, CSR write
//                         data / aux / flush / busy out)
//  Options     : TRAP_MTVAL_EN - when defined, mtval carries the faulting
//                address / instruction / pc; otherwise traps write 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module trap_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int XLEN         = 32
) (
    input  wire logic   clk_i,
    input  wire logic   rst_ni,
    trap_ctrl_if.slave  bus
);

    localparam int CNT_W = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_COMMIT = 2'd1,
        ST_DRAIN  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CNT_W-1:0] r_cnt;

    logic [2:0]      w_irq_pend;
    logic            w_trap;
    logic            w_req;
    logic            w_accept;
    logic [XLEN-1:0] w_cause;
    logic [XLEN-1:0] w_tval;
    logic [XLEN-1:0] w_mstatus_trap;
    logic [XLEN-1:0] w_mstatus_mret;

    logic            r_we;
    logic            r_flush;
    logic            r_busy;
    logic            r_aux;
    logic [XLEN-1:0] r_mcause;
    logic [XLEN-1:0] r_mepc;
    logic [XLEN-1:0] r_mtval;
    logic [XLEN-1:0] r_mstatus;

    // Pending interrupts, bit order {external, software, timer}
    assign w_irq_pend = bus.irq_i
                      & {bus.mie_i[11], bus.mie_i[3], bus.mie_i[7]}
                      & {3{bus.mstatus_i[3]}};
    assign w_trap     = (|w_irq_pend) || (|bus.exc_i);
    assign w_req      = bus.valid_i && (w_trap || bus.mret_i);
    assign w_accept   = (r_state == ST_IDLE) && w_req;

    // Cause selection in priority order; exc_i bit order already matches
    // the synchronous exception priority.
    always_comb begin
        w_cause = '0;
        if      (w_irq_pend[2]) w_cause = {1'b1, (XLEN-1)'(11)};
        else if (w_irq_pend[1]) w_cause = {1'b1, (XLEN-1)'(3)};
        else if (w_irq_pend[0]) w_cause = {1'b1, (XLEN-1)'(7)};
        else if (bus.exc_i[0])  w_cause = XLEN'(0);
        else if (bus.exc_i[1])  w_cause = XLEN'(2);
        else if (bus.exc_i[2])  w_cause = XLEN'(3);
        else if (bus.exc_i[3])  w_cause = XLEN'(11);
        else if (bus.exc_i[4])  w_cause = XLEN'(4);
        else if (bus.exc_i[5])  w_cause = XLEN'(6);
    end

`ifdef TRAP_MTVAL_EN
    // Interrupts and ecall leave mtval at zero.
    always_comb begin
        w_tval = '0;
        if (w_irq_pend == 3'b000) begin
            if      (bus.exc_i[0]) w_tval = bus.badaddr_i;
            else if (bus.exc_i[1]) w_tval = bus.instr_i;
            else if (bus.exc_i[2]) w_tval = bus.pc_i;
            else if (bus.exc_i[3]) w_tval = '0;
            else if (bus.exc_i[4]) w_tval = bus.badaddr_i;
            else if (bus.exc_i[5]) w_tval = bus.badaddr_i;
        end
    end

    logic w_unused;
    assign w_unused = ^bus.mie_i;
`else
    assign w_tval = '0;

    logic w_unused;
    assign w_unused = ^{bus.mie_i, bus.badaddr_i, bus.instr_i};
`endif

    // Trap entry: MPIE <= MIE, MIE <= 0, MPP <= M
    always_comb begin
        w_mstatus_trap        = bus.mstatus_i;
        w_mstatus_trap[7]     = bus.mstatus_i[3];
        w_mstatus_trap[3]     = 1'b0;
        w_mstatus_trap[12:11] = 2'b11;
    end

    // MRET: MIE <= MPIE, MPIE <= 1, MPP <= M
    always_comb begin
        w_mstatus_mret        = bus.mstatus_i;
        w_mstatus_mret[3]     = bus.mstatus_i[7];
        w_mstatus_mret[7]     = 1'b1;
        w_mstatus_mret[12:11] = 2'b11;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_req) w_state_nxt = ST_COMMIT;
            ST_COMMIT: w_state_nxt = (FLUSH_CYCLES == 0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN:  if (r_cnt <= CNT_W'(1)) w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            // Loaded at acceptance, decremented only while draining
            if (w_accept)
                r_cnt <= CNT_W'(FLUSH_CYCLES);
            else if (r_state == ST_DRAIN)
                r_cnt <= r_cnt - 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_we      <= 1'b0;
            r_flush   <= 1'b0;
            r_busy    <= 1'b0;
            r_aux     <= 1'b0;
            r_mcause  <= '0;
            r_mepc    <= '0;
            r_mtval   <= '0;
            r_mstatus <= '0;
        end else begin
            r_we    <= w_accept;
            r_flush <= w_accept;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_accept) begin
                if (w_trap) begin
                    r_aux     <= 1'b0;
                    r_mcause  <= w_cause;
                    r_mepc    <= {bus.pc_i[XLEN-1:2], 2'b00};
                    r_mtval   <= w_tval;
                    r_mstatus <= w_mstatus_trap;
                end else begin
                    // MRET passes CSRs through so the write is a no-op on them
                    r_aux     <= 1'b1;
                    r_mcause  <= bus.mcause_i;
                    r_mepc    <= bus.mepc_i;
                    r_mtval   <= bus.mtval_i;
                    r_mstatus <= w_mstatus_mret;
                end
            end else if (w_state_nxt == ST_IDLE) begin
                r_aux <= 1'b0;
            end
        end
    end

    assign bus.we_exc_o  = r_we;
    assign bus.flush_o   = r_flush;
    assign bus.busy_o    = r_busy;
    assign bus.aux_o     = r_aux;
    assign bus.mcause_o  = r_mcause;
    assign bus.mepc_o    = r_mepc;
    assign bus.mtval_o   = r_mtval;
    assign bus.mstatus_o = r_mstatus;

endmodule
`default_nettype wire
